// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue/writeback front end.
//   fpu_op_e       3-bit encoded FP operation as issued by the core
//   issue_state_e  sequencing states of fpu_issue
//   op_to_onehot   encoded op -> one-hot FPU opcode (bit n = op n)
package fpu_pkg;

    localparam int unsigned FPU_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_FADD  = 3'd0,
        OP_FSUB  = 3'd1,
        OP_FMUL  = 3'd2,
        OP_FDIV  = 3'd3,
        OP_FSQRT = 3'd4,
        OP_FTOI  = 3'd5,
        OP_ITOF  = 3'd6,
        OP_FABS  = 3'd7
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } issue_state_e;

    function automatic logic [7:0] op_to_onehot(input fpu_op_e op);
        return 8'b1 << op;
    endfunction

endpackage

// File: rtl/fpu_issue.sv
// Issue/writeback front end for the FPU: takes one request at a time from the core,
// pulses a one-hot opcode for one cycle, holds the operands while the FPU works,
// then presents the result (or a forced timeout response) to writeback.
//
// Ports:
//   sys_clk, rstn                      clock, async active-low reset
//   req_valid/req_ready                core request handshake
//   req_op, req_rs1, req_rs2, req_rd   encoded op, operands, destination tag
//   fpu_opcode, fpu_x1, fpu_x2         one-hot opcode pulse and held operands to the FPU
//   fpu_y, fpu_ovf, fpu_unf, fpu_valid result coming back from the FPU
//   resp_valid/resp_ready              writeback handshake
//   resp_data, resp_rd, resp_timeout   response payload
//   flag_ovf, flag_unf, flag_clr       sticky exception flags and their clear
//   busy                               an operation is in flight
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TAG_W          = 5
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [FPU_DATA_W-1:0] req_rs1,
    input  logic [FPU_DATA_W-1:0] req_rs2,
    input  logic [TAG_W-1:0]      req_rd,
    output logic [7:0]            fpu_opcode,
    output logic [FPU_DATA_W-1:0] fpu_x1,
    output logic [FPU_DATA_W-1:0] fpu_x2,
    input  logic [FPU_DATA_W-1:0] fpu_y,
    input  logic                  fpu_ovf,
    input  logic                  fpu_unf,
    input  logic                  fpu_valid,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [FPU_DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]      resp_rd,
    output logic                  resp_timeout,
    output logic                  flag_ovf,
    output logic                  flag_unf,
    input  logic                  flag_clr,
    output logic                  busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    issue_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TAG_W-1:0]      rd_q, rd_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [FPU_DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [FPU_DATA_W-1:0] resp_data_q, resp_data_d;
    logic [TAG_W-1:0]      resp_rd_q, resp_rd_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic                  flag_ovf_q, flag_ovf_d, flag_unf_q, flag_unf_d;
    logic                  set_ovf, set_unf;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        opcode_d       = opcode_q;
        x1_d           = x1_q;
        x2_d           = x2_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_rd_d      = resp_rd_q;
        resp_timeout_d = resp_timeout_q;
        set_ovf        = 1'b0;
        set_unf        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    x1_d     = req_rs1;
                    x2_d     = req_rs2;
                    rd_d     = req_rd;
                    opcode_d = op_to_onehot(fpu_op_e'(req_op));
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // fpu_valid is deliberately not looked at here
                opcode_d = '0;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A real result takes priority over a timeout landing in the same cycle
                if (fpu_valid) begin
                    resp_data_d    = fpu_y;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_rd_d      = rd_q;
                    set_ovf        = fpu_ovf;
                    set_unf        = fpu_unf;
                    state_d        = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
                    resp_valid_d   = 1'b1;
                    resp_rd_d      = rd_q;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture beats a simultaneous clear
        flag_ovf_d = set_ovf | (flag_ovf_q & ~flag_clr);
        flag_unf_d = set_unf | (flag_unf_q & ~flag_clr);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_q           <= '0;
            opcode_q       <= '0;
            x1_q           <= '0;
            x2_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_rd_q      <= '0;
            resp_timeout_q <= 1'b0;
            flag_ovf_q     <= 1'b0;
            flag_unf_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            opcode_q       <= opcode_d;
            x1_q           <= x1_d;
            x2_q           <= x2_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_rd_q      <= resp_rd_d;
            resp_timeout_q <= resp_timeout_d;
            flag_ovf_q     <= flag_ovf_d;
            flag_unf_q     <= flag_unf_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign fpu_opcode   = opcode_q;
    assign fpu_x1       = x1_q;
    assign fpu_x2       = x2_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_rd      = resp_rd_q;
    assign resp_timeout = resp_timeout_q;
    assign flag_ovf     = flag_ovf_q;
    assign flag_unf     = flag_unf_q;

endmodule
